// File: rtl/wb_obi_bridge.sv
// Wishbone classic slave to OBI initiator bridge, one outstanding OBI transaction.
// Optional watchdog enabled by defining WB_OBI_TIMEOUT_EN.
module wb_obi_bridge #(
  parameter int unsigned               SOC_ADDR_WIDTH = 32,
  parameter logic [SOC_ADDR_WIDTH-1:0] OBI_BASE_ADDR  = 32'h0000_0000,
  parameter logic [SOC_ADDR_WIDTH-1:0] WINDOW_MASK    = 32'h001F_FFFF,
  parameter int unsigned               TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [SOC_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [31:0]               wb_wdata_i,
  input  logic                      wb_wr_en_i,
  input  logic [3:0]                wb_byte_en_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_cyc_i,
  output logic [31:0]               wb_rdata_o,
  output logic                      wb_ack_o,
  output logic                      obi_req_o,
  input  logic                      obi_gnt_i,
  output logic [SOC_ADDR_WIDTH-1:0] obi_addr_o,
  output logic                      obi_we_o,
  output logic [3:0]                obi_be_o,
  output logic [31:0]               obi_wdata_o,
  input  logic                      obi_rvalid_i,
  input  logic [31:0]               obi_rdata_i,
  output logic                      timeout_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    ACK,
    DRAIN_REQ,
    DRAIN_RSP
  } state_e;

  state_e state_q;
  logic   timeout_fire;

  if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("wb_obi_bridge: TIMEOUT_CYCLES must be >= 2");
  end

`ifdef WB_OBI_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // Fires only when the pending gnt/rvalid does not complete in the same cycle.
  always_comb begin
    timeout_fire = 1'b0;
    if (wb_cyc_i && (cnt_q == CNT_LAST)) begin
      timeout_fire = ((state_q == REQ) && !obi_gnt_i) ||
                     ((state_q == RESP) && !obi_rvalid_i);
    end
  end

  // Counter saturates so a late grant cannot wrap it back to a fresh budget.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if (((state_q == REQ) || (state_q == RESP)) && (cnt_q != CNT_LAST)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      obi_req_o   <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_rdata_o  <= '0;
      obi_addr_o  <= '0;
      obi_we_o    <= 1'b0;
      obi_be_o    <= '0;
      obi_wdata_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
            obi_addr_o  <= (wb_addr_i & WINDOW_MASK) | OBI_BASE_ADDR;
            obi_we_o    <= wb_wr_en_i;
            obi_be_o    <= wb_byte_en_i;
            obi_wdata_o <= wb_wdata_i;
            obi_req_o   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (obi_gnt_i) begin
            obi_req_o <= 1'b0;
            state_q   <= wb_cyc_i ? RESP : DRAIN_RSP;
          end else if (!wb_cyc_i) begin
            state_q <= DRAIN_REQ;
          end else if (timeout_fire) begin
            wb_ack_o   <= 1'b1;
            wb_rdata_o <= 32'hDEAD_BEEF;
            state_q    <= DRAIN_REQ;
          end
        end
        RESP: begin
          if (obi_rvalid_i) begin
            wb_rdata_o <= obi_we_o ? '0 : obi_rdata_i;
            wb_ack_o   <= 1'b1;
            state_q    <= ACK;
          end else if (!wb_cyc_i) begin
            state_q <= DRAIN_RSP;
          end else if (timeout_fire) begin
            wb_ack_o   <= 1'b1;
            wb_rdata_o <= 32'hDEAD_BEEF;
            state_q    <= DRAIN_RSP;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        DRAIN_REQ: begin
          if (obi_gnt_i) begin
            obi_req_o <= 1'b0;
            state_q   <= DRAIN_RSP;
          end
        end
        DRAIN_RSP: begin
          if (obi_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_obi_bridge.sv
// Directed scoreboard bench for wb_obi_bridge; timeout scenario runs when WB_OBI_TIMEOUT_EN is defined.
module tb_wb_obi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] wb_addr_i = '0;
  logic [31:0] wb_wdata_i = '0;
  logic        wb_wr_en_i = 1'b0;
  logic [3:0]  wb_byte_en_i = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic [31:0] wb_rdata_o;
  logic        wb_ack_o;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = '0;
  logic        timeout_o;

  wb_obi_bridge #(
    .SOC_ADDR_WIDTH(32),
    .OBI_BASE_ADDR (32'h0000_0000),
    .WINDOW_MASK   (32'h001F_FFFF),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wb_addr_i   (wb_addr_i),
    .wb_wdata_i  (wb_wdata_i),
    .wb_wr_en_i  (wb_wr_en_i),
    .wb_byte_en_i(wb_byte_en_i),
    .wb_stb_i    (wb_stb_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_rdata_o  (wb_rdata_o),
    .wb_ack_o    (wb_ack_o),
    .obi_req_o   (obi_req_o),
    .obi_gnt_i   (obi_gnt_i),
    .obi_addr_o  (obi_addr_o),
    .obi_we_o    (obi_we_o),
    .obi_be_o    (obi_be_o),
    .obi_wdata_o (obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i (obi_rdata_i),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned ack_cnt = 0;
  int unsigned req_starts = 0;
  logic        req_prev = 1'b0;
  logic [31:0] exp_q[$];

  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_we;
  logic [3:0]  exp_be;
  logic [31:0] cur_rd;

  always @(negedge clk_i) begin
    if (wb_ack_o) ack_cnt++;
    if (obi_req_o && !req_prev) req_starts++;
    req_prev = obi_req_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb_begin(input logic [31:0] addr, input logic [31:0] mapped, input logic we,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] rd, input bit expect_ack);
    wb_addr_i    = addr;
    wb_wr_en_i   = we;
    wb_wdata_i   = wdata;
    wb_byte_en_i = be;
    wb_cyc_i     = 1'b1;
    wb_stb_i     = 1'b1;
    exp_addr     = mapped;
    exp_we       = we;
    exp_be       = be;
    exp_wdata    = wdata;
    cur_rd       = rd;
    if (expect_ack) exp_q.push_back(we ? 32'h0 : rd);
  endtask

  task automatic chk_payload(input string tag);
    chk({tag, "_req"}, {31'b0, obi_req_o}, 32'h1);
    chk({tag, "_addr"}, obi_addr_o, exp_addr);
    chk({tag, "_we_be"}, {27'b0, obi_we_o, obi_be_o}, {27'b0, exp_we, exp_be});
    chk({tag, "_wdata"}, obi_wdata_o, exp_wdata);
  endtask

  task automatic chk_ack_data(input string tag);
    chk({tag, "_ack"}, {31'b0, wb_ack_o}, 32'h1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      chk({tag, "_rdata"}, wb_rdata_o, exp_q.pop_front());
    end
  endtask

  // Entered at #1 after the edge that raised obi_req_o.
  task automatic serve(input string tag, input int gnt_delay, input int rv_delay);
    for (int i = 0; i < gnt_delay; i++) begin
      chk_payload(tag);
      chk({tag, "_no_early_ack"}, {31'b0, wb_ack_o}, 32'h0);
      tick();
    end
    chk_payload(tag);
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i = 1'b0;
    chk({tag, "_req_drop"}, {31'b0, obi_req_o}, 32'h0);
    for (int i = 0; i < rv_delay; i++) begin
      chk({tag, "_wait_ack"}, {31'b0, wb_ack_o}, 32'h0);
      tick();
    end
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = cur_rd;
    tick();
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = 32'h0;
    wb_cyc_i     = 1'b0;
    wb_stb_i     = 1'b0;
    chk_ack_data(tag);
    tick();
    chk({tag, "_ack_pulse"}, {31'b0, wb_ack_o}, 32'h0);
    chk({tag, "_no_dup_req"}, {31'b0, obi_req_o}, 32'h0);
  endtask

  task automatic do_xfer(input string tag, input logic [31:0] addr, input logic [31:0] mapped,
                         input logic we, input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] rd, input int gnt_delay, input int rv_delay);
    wb_begin(addr, mapped, we, wdata, be, rd, 1'b1);
    tick();
    serve(tag, gnt_delay, rv_delay);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {31'b0, obi_req_o}, 32'h0);
    chk({tag, "_ack"}, {31'b0, wb_ack_o}, 32'h0);
    chk({tag, "_rdata"}, wb_rdata_o, 32'h0);
    chk({tag, "_addr"}, obi_addr_o, 32'h0);
    chk({tag, "_we_be"}, {27'b0, obi_we_o, obi_be_o}, 32'h0);
    chk({tag, "_wdata"}, obi_wdata_o, 32'h0);
    chk({tag, "_timeout"}, {31'b0, timeout_o}, 32'h0);
  endtask

  initial begin
    int unsigned a0;
    int unsigned r0;
    int          waited;

    // Reset
    tick();
    tick();
    chk_all_zero("reset");
    rst_ni = 1'b1;
    tick();

    // Write with immediate gnt/rvalid: ack three edges after stb, rdata forced to 0
    do_xfer("wr40", 32'h0000_0040, 32'h0000_0040, 1'b1, 32'hA5A5_1234, 4'hF, 32'h1111_2222, 0, 0);

    // Read with gnt after 4 waiting cycles, rvalid two cycles after gnt
    do_xfer("rd20010", 32'h0002_0010, 32'h0002_0010, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 4, 1);

    // Zero byte enables pass through; upper address bits are masked away
    do_xfer("wr_be0", 32'hFFE0_0008, 32'h0000_0008, 1'b1, 32'h0BAD_F00D, 4'h0, 32'h5555_5555, 1, 0);

    // Cycle dropped while request pending: request held, response drained, no ack
    a0 = ack_cnt;
    wb_begin(32'h0000_0100, 32'h0000_0100, 1'b0, 32'h0, 4'h3, 32'h7777_8888, 1'b0);
    tick();
    chk_payload("drop");
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    tick();
    chk_payload("drop_hold1");
    tick();
    chk_payload("drop_hold2");
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i = 1'b0;
    chk("drop_req_released", {31'b0, obi_req_o}, 32'h0);
    tick();
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'h7777_8888;
    tick();
    obi_rvalid_i = 1'b0;
    tick();
    chk("drop_no_ack", ack_cnt, a0);
    do_xfer("after_drop", 32'h0000_0104, 32'h0000_0104, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 0, 0);

    // Reset pulse during RESP, then a stray rvalid
    a0 = ack_cnt;
    wb_begin(32'h0000_0200, 32'h0000_0200, 1'b1, 32'hFEED_FACE, 4'hC, 32'h0, 1'b0);
    tick();
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni   = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    chk_all_zero("rst_resp");
    tick();
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'h9999_9999;
    tick();
    obi_rvalid_i = 1'b0;
    chk("stray_no_req", {31'b0, obi_req_o}, 32'h0);
    tick();
    chk("stray_no_ack", ack_cnt, a0);
    do_xfer("after_rst", 32'h0000_0300, 32'h0000_0300, 1'b0, 32'h0, 4'hF, 32'h0F0F_A5A5, 2, 0);

`ifdef WB_OBI_TIMEOUT_EN
    // No grant: watchdog acks with the poison word and leaves the request up
    wb_begin(32'h0000_0400, 32'h0000_0400, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    waited = 0;
    tick();
    while (!wb_ack_o && waited < 40) begin
      tick();
      waited++;
    end
    chk("to_within_budget", {31'b0, (waited < 40)}, 32'h1);
    chk_ack_data("to");
    chk("to_flag", {31'b0, timeout_o}, 32'h1);
    chk("to_req_held", {31'b0, obi_req_o}, 32'h1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    tick();
    chk("to_ack_pulse", {31'b0, wb_ack_o}, 32'h0);
    a0 = ack_cnt;
    wb_begin(32'h0000_0080, 32'h0000_0080, 1'b0, 32'h0, 4'hF, 32'h600D_CAFE, 1'b1);
    repeat (3) tick();
    chk("to_stall_no_ack", ack_cnt, a0);
    chk("to_stall_old_addr", obi_addr_o, 32'h0000_0400);
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i = 1'b0;
    tick();
    obi_rvalid_i = 1'b1;
    tick();
    obi_rvalid_i = 1'b0;
    chk("to_drain_no_ack", ack_cnt, a0);
    tick();
    serve("to_next", 0, 0);
    chk("to_sticky", {31'b0, timeout_o}, 32'h1);
`else
    waited = 0;
    chk("no_timeout_flag", {31'b0, timeout_o} | 32'(waited), 32'h0);
`endif

    // Back-to-back reads: exactly two requests and two acks
    a0 = ack_cnt;
    r0 = req_starts;
    do_xfer("b2b0", 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0, 4'hF, 32'h0000_AAAA, 0, 0);
    do_xfer("b2b4", 32'h0000_0004, 32'h0000_0004, 1'b0, 32'h0, 4'hF, 32'h0000_BBBB, 0, 0);
    tick();
    tick();
    chk("b2b_req_count", req_starts - r0, 32'd2);
    chk("b2b_ack_count", ack_cnt - a0, 32'd2);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
